// File: rtl/dmem_responder_if.sv
// ---------------------------------------------------------------------------
// dmem_responder_if
// Bundles the request/response signals between the memory-access pipeline
// stage (master) and the data-memory responder (slave).
//
// Signals:
//   mem_ce_i    request valid (master -> slave)
//   mem_addr_i  32-bit byte address (master -> slave)
//   mem_we_i    1 = store word, 0 = load word (master -> slave)
//   mem_data_i  store data (master -> slave)
//   mem_data_o  registered load data (slave -> master)
//   mem_ready_o one-cycle response strobe (slave -> master)
//   mem_err_o   misaligned-access flag, valid with mem_ready_o (slave -> master)
//
// Handshake: the master raises mem_ce_i with address/we/data and keeps them
// stable while it stalls. The slave samples the request on the first rising
// edge at which it is idle, then ignores the request inputs until it has
// returned a single-cycle mem_ready_o pulse. The master may drop mem_ce_i (or
// present the next request) in the cycle that mem_ready_o is high.
// ---------------------------------------------------------------------------
interface dmem_responder_if;
    logic        mem_ce_i;
    logic [31:0] mem_addr_i;
    logic        mem_we_i;
    logic [31:0] mem_data_i;
    logic [31:0] mem_data_o;
    logic        mem_ready_o;
    logic        mem_err_o;

    modport master (
        output mem_ce_i, mem_addr_i, mem_we_i, mem_data_i,
        input  mem_data_o, mem_ready_o, mem_err_o
    );

    modport slave (
        input  mem_ce_i, mem_addr_i, mem_we_i, mem_data_i,
        output mem_data_o, mem_ready_o, mem_err_o
    );
endinterface

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Word-wide data memory with a fixed, programmable response latency.
// A request accepted in IDLE spends WAIT_CYC cycles in WAIT, then one cycle
// in DONE where mem_ready_o pulses. Stores write the array and loads update
// the registered mem_data_o on the edge that enters DONE.
//
// Parameters:
//   ADDR_W    word-address width; storage is 2^ADDR_W 32-bit words
//   WAIT_CYC  wait cycles between acceptance and response (0..15)
//
// Ports:
//   clk        sole clock, rising edge
//   resetn     asynchronous active-low reset (array contents are kept)
//   bus        dmem_responder_if.slave request/response bundle
//   dbg_state  current FSM state (0 IDLE, 1 WAIT, 2 DONE)
//
// Optional feature: define DMEM_ALIGN_CHECK_EN to flag accesses whose byte
// address is not word aligned. Such accesses do not write, load zero, and
// raise mem_err_o alongside mem_ready_o. Without the macro addr[1:0] is
// ignored and mem_err_o stays 0.
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int ADDR_W   = 10,
    parameter int WAIT_CYC = 2
) (
    input  logic               clk,
    input  logic               resetn,
    dmem_responder_if.slave    bus,
    output logic [1:0]         dbg_state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] idx_q;
    logic              we_q;
    logic [31:0]       wdata_q;
    logic [31:0]       data_q;
    logic              ready_q;
    logic              err_q;

    logic [31:0]       mem [0:(1<<ADDR_W)-1];

    // Transaction fields as seen at the edge entering DONE. With WAIT_CYC=0
    // that edge is the acceptance edge itself, so the live inputs are used
    // while idle; otherwise the latched copy governs.
    logic              in_idle;
    logic              accept;
    logic              enter_done;
    logic [ADDR_W-1:0] t_idx;
    logic              t_we;
    logic [31:0]       t_wdata;
    logic              misalign;

    assign in_idle = (state == ST_IDLE);
    assign accept  = in_idle && bus.mem_ce_i;
    assign t_idx   = in_idle ? bus.mem_addr_i[ADDR_W+1:2] : idx_q;
    assign t_we    = in_idle ? bus.mem_we_i : we_q;
    assign t_wdata = in_idle ? bus.mem_data_i : wdata_q;

    // resetn gates the array write so a request presented during reset can
    // never reach memory through the WAIT_CYC=0 path.
    assign enter_done = resetn &&
                        ((accept && (WAIT_CYC == 0)) ||
                         ((state == ST_WAIT) && (cnt == 4'd0)));

`ifdef DMEM_ALIGN_CHECK_EN
    logic [1:0] lo_q;
    logic [1:0] t_lo;

    assign t_lo     = in_idle ? bus.mem_addr_i[1:0] : lo_q;
    assign misalign = (t_lo != 2'b00);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lo_q <= 2'b00;
        end else if (accept) begin
            lo_q <= bus.mem_addr_i[1:0];
        end
    end
`else
    assign misalign = 1'b0;
`endif

    // Control FSM, request latch and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= 32'h0;
            data_q  <= 32'h0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // Ready and err are registered copies of "entering DONE", so they
            // are high for exactly the DONE cycle.
            ready_q <= enter_done;
            err_q   <= enter_done && misalign;

            if (enter_done && !t_we) begin
                data_q <= misalign ? 32'h0 : mem[t_idx];
            end

            case (state)
                ST_IDLE: begin
                    if (bus.mem_ce_i) begin
                        idx_q   <= bus.mem_addr_i[ADDR_W+1:2];
                        we_q    <= bus.mem_we_i;
                        wdata_q <= bus.mem_data_i;
                        if (WAIT_CYC == 0) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= 4'(WAIT_CYC - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Storage array: never reset, written only on the edge entering DONE.
    always_ff @(posedge clk) begin
        if (enter_done && t_we && !misalign) begin
            mem[t_idx] <= t_wdata;
        end
    end

    assign bus.mem_data_o  = data_q;
    assign bus.mem_ready_o = ready_q;
    assign bus.mem_err_o   = err_q;
    assign dbg_state       = state;

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
// Two responders (WAIT_CYC=2 and WAIT_CYC=0) share one request stream. Each
// has a transaction-level model (acceptance time, completion time, word
// memory) whose expected outputs are compared on every falling edge, plus
// hand-computed literal checks for the directed scenarios.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int ADDR_W = 10;

`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    // ---------------- shared request stream ----------------
    logic        ce = 1'b0;
    logic [31:0] addr = 32'h0;
    logic        we = 1'b0;
    logic [31:0] wdata = 32'h0;

    logic [1:0]  rdy;
    logic [1:0]  err;
    logic [31:0] dout [2];
    logic [1:0]  dbg [2];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- DUTs + per-instance models ----------------
    for (genvar g = 0; g < 2; g++) begin : u
        localparam int W = (g == 0) ? 2 : 0;

        dmem_responder_if bus ();
        assign bus.mem_ce_i   = ce;
        assign bus.mem_addr_i = addr;
        assign bus.mem_we_i   = we;
        assign bus.mem_data_i = wdata;
        assign rdy[g]  = bus.mem_ready_o;
        assign err[g]  = bus.mem_err_o;
        assign dout[g] = bus.mem_data_o;

        dmem_responder #(.ADDR_W(ADDR_W), .WAIT_CYC(W)) dut (
            .clk       (clk),
            .resetn    (resetn),
            .bus       (bus.slave),
            .dbg_state (dbg[g])
        );

        // Model: a request seen at edge t while free is accepted, completes
        // at edge t+W (outputs visible the following cycle), and the next
        // request can be accepted from edge t+W+2.
        logic [31:0] mm [int];
        longint      t;
        longint      done_at;
        longint      free_at;
        bit          pend;
        int          p_idx;
        bit          p_we;
        bit          p_mis;
        logic [31:0] p_data;
        logic        exp_ready;
        logic        exp_err;
        logic [31:0] exp_data;
        bit          data_known;

        always @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                t = 0; free_at = 0; pend = 0; done_at = 0;
                exp_ready = 1'b0; exp_err = 1'b0; exp_data = 32'h0; data_known = 1;
            end else begin
                exp_ready = 1'b0;
                exp_err   = 1'b0;
                if (t >= free_at && ce) begin
                    pend    = 1;
                    p_idx   = int'((addr >> 2) % (1 << ADDR_W));
                    p_we    = we;
                    p_data  = wdata;
                    p_mis   = ALIGN_EN && (addr % 4 != 0);
                    done_at = t + W;
                    free_at = t + W + 2;
                end
                if (pend && t == done_at) begin
                    pend      = 0;
                    exp_ready = 1'b1;
                    exp_err   = p_mis;
                    if (p_we) begin
                        if (!p_mis) mm[p_idx] = p_data;
                    end else if (p_mis) begin
                        exp_data = 32'h0; data_known = 1;
                    end else if (mm.exists(p_idx)) begin
                        exp_data = mm[p_idx]; data_known = 1;
                    end else begin
                        data_known = 0;
                    end
                end
                t = t + 1;
            end
        end

        // Scoreboard compare on every falling edge.
        always @(negedge clk) begin
            chk($sformatf("u%0d ready", g), {31'h0, rdy[g]}, {31'h0, exp_ready});
            chk($sformatf("u%0d err", g), {31'h0, err[g]}, {31'h0, exp_err});
            if (data_known) chk($sformatf("u%0d data", g), dout[g], exp_data);
        end
    end

    // ---------------- driver tasks ----------------
    int          lat [2];
    int          pulses [2];
    logic [31:0] dat_at [2];
    logic        err_at [2];

    // One-cycle request, then observe both responders for 12 cycles.
    task automatic txn(input logic t_we, input logic [31:0] t_addr, input logic [31:0] t_data);
        @(negedge clk);
        ce = 1'b1; we = t_we; addr = t_addr; wdata = t_data;
        @(posedge clk);
        @(negedge clk);
        ce = 1'b0; addr = $urandom; wdata = $urandom; we = 1'($urandom_range(0, 1));
        for (int g = 0; g < 2; g++) begin
            lat[g] = -1; pulses[g] = 0; dat_at[g] = 'x; err_at[g] = 1'bx;
        end
        for (int k = 1; k <= 12; k++) begin
            for (int g = 0; g < 2; g++) begin
                if (rdy[g]) begin
                    pulses[g]++;
                    if (lat[g] < 0) begin
                        lat[g] = k; dat_at[g] = dout[g]; err_at[g] = err[g];
                    end
                end
            end
            if (k < 12) @(negedge clk);
        end
        if (lat[0] < 0 || lat[1] < 0) begin
            checks++; errors++;
            $display("FAIL timeout: no ready within 12 cycles (lat0=%0d lat1=%0d)", lat[0], lat[1]);
        end
    endtask

    // ---------------- stimulus ----------------
    int alt_cnt;

    initial begin
        repeat (3) @(negedge clk);
        // Reset state.
        chk("reset ready0", {31'h0, rdy[0]}, 32'h0);
        chk("reset ready1", {31'h0, rdy[1]}, 32'h0);
        chk("reset err0", {31'h0, err[0]}, 32'h0);
        chk("reset data0", dout[0], 32'h0);
        chk("reset data1", dout[1], 32'h0);
        resetn = 1'b1;

        // Store, latency and pulse width.
        txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        chk("store lat W2", 32'(lat[0]), 32'd3);
        chk("store lat W0", 32'(lat[1]), 32'd1);
        chk("pulse width W2", 32'(pulses[0]), 32'd1);
        chk("pulse width W0", 32'(pulses[1]), 32'd1);
        chk("store keeps data0", dout[0], 32'h0);

        // Load back, held afterwards.
        txn(1'b0, 32'h0000_0010, 32'h0);
        chk("load data W2", dat_at[0], 32'hDEAD_BEEF);
        chk("load data W0", dat_at[1], 32'hDEAD_BEEF);
        chk("load held W2", dout[0], 32'hDEAD_BEEF);

        // Address wrap modulo 2^(ADDR_W+2).
        txn(1'b1, 32'h0000_1010, 32'h1234_5678);
        txn(1'b0, 32'h0000_0010, 32'h0);
        chk("wrap W2", dat_at[0], 32'h1234_5678);
        chk("wrap W0", dat_at[1], 32'h1234_5678);

        // Misaligned store.
        txn(1'b1, 32'h0000_0012, 32'h0BAD_F00D);
        chk("misalign err W2", {31'h0, err_at[0]}, {31'h0, ALIGN_EN});
        chk("misalign err W0", {31'h0, err_at[1]}, {31'h0, ALIGN_EN});
        txn(1'b0, 32'h0000_0010, 32'h0);
        chk("misalign load W2", dat_at[0], ALIGN_EN ? 32'h1234_5678 : 32'h0BAD_F00D);
        chk("misalign load W0", dat_at[1], ALIGN_EN ? 32'h1234_5678 : 32'h0BAD_F00D);

        // Reset during WAIT discards the pending store (W0 already completed).
        txn(1'b1, 32'h0000_0020, 32'h1111_2222);
        @(negedge clk);
        ce = 1'b1; we = 1'b1; addr = 32'h0000_0020; wdata = 32'hAAAA_5555;
        @(posedge clk);
        @(negedge clk);
        ce = 1'b0;
        #2 resetn = 1'b0;
        #1;
        chk("mid reset ready0", {31'h0, rdy[0]}, 32'h0);
        chk("mid reset ready1", {31'h0, rdy[1]}, 32'h0);
        chk("mid reset data0", dout[0], 32'h0);
        chk("mid reset data1", dout[1], 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        txn(1'b0, 32'h0000_0020, 32'h0);
        chk("reset discard W2", dat_at[0], 32'h1111_2222);
        chk("reset completed W0", dat_at[1], 32'hAAAA_5555);

        // Continuous ce with alternating store/load pairs.
        alt_cnt = 0;
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            if (i > 0 && rdy[1]) alt_cnt++;
            if (i < 16) begin
                ce = 1'b1;
                if (i % 2 == 0) begin
                    we    = ((i / 2) % 2 == 0);
                    addr  = 32'h40 + 32'(((i / 4) % 4) * 4);
                    wdata = $urandom;
                end
            end else begin
                ce = 1'b0;
            end
        end
        chk("alt ready count W0", 32'(alt_cnt), 32'd8);
        repeat (6) @(negedge clk);

        // Random traffic with occasional asynchronous reset.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            ce    = ($urandom_range(0, 3) != 0);
            we    = 1'($urandom_range(0, 1));
            addr  = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 15)) << 2);
            if ($urandom_range(0, 7) == 0) addr = addr | 32'($urandom_range(1, 3));
            wdata = $urandom;
            if ($urandom_range(0, 299) == 0) begin
                #2 resetn = 1'b0;
                #1 resetn = 1'b1;
            end
        end
        @(negedge clk);
        ce = 1'b0;
        repeat (6) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning word-address width (storage = 2^ADDR_W 32-bit words).
REQ-002 SHALL have parameter WAIT_CYC, default 2, meaning wait cycles inserted between request acceptance and response (legal 0..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port mem_ce_i  input  1  request valid from the memory-access pipeline stage.
REQ-006 SHALL have port mem_addr_i  input  32  byte address of request.
REQ-007 SHALL have port mem_we_i  input  1  1 = store word, 0 = load word.
REQ-008 SHALL have port mem_data_i  input  32  store data.
REQ-009 SHALL have port mem_data_o  output  32  load data, registered.
REQ-010 SHALL have port mem_ready_o  output  1  one-cycle response strobe; requester stalls while ce high and ready low.
REQ-011 SHALL have port mem_err_o  output  1  misaligned-access flag (see Configuration).

Function
REQ-012 SHALL implement FSM states IDLE, WAIT, DONE; reset state IDLE.
REQ-013 In IDLE with mem_ce_i=1 at a rising edge, SHALL latch addr, we, wdata; next state DONE if WAIT_CYC=0, else WAIT with counter=WAIT_CYC-1.
REQ-014 In WAIT, SHALL go to DONE when counter=0, else decrement counter; WAIT therefore lasts exactly WAIT_CYC cycles.
REQ-015 In DONE, SHALL drive mem_ready_o=1 for exactly one cycle, then return to IDLE unconditionally; no request is accepted in the DONE cycle.
REQ-016 Total latency: ready asserted in cycle N+1+WAIT_CYC for a request sampled at edge N; back-to-back requests spaced WAIT_CYC+2 cycles.
REQ-017 Request inputs SHALL be ignored in WAIT and DONE; latched values govern the transaction.
REQ-018 Word index SHALL be latched addr[ADDR_W+1:2]; upper bits ignored (addresses wrap modulo 2^(ADDR_W+2)).
REQ-019 Store SHALL write latched data to the array at the edge entering DONE; mem_data_o unchanged by a store.
REQ-020 Load SHALL register array[index] into mem_data_o at the edge entering DONE; mem_data_o holds until the next load completes.
REQ-021 A load issued after a completed store to the same index SHALL return the stored value.
REQ-022 mem_ready_o SHALL be 0 in IDLE and WAIT.

Reset
REQ-023 On resetn=0 (any state, asynchronously): state IDLE, counter 0, mem_data_o=0x00000000, mem_ready_o=0, mem_err_o=0.
REQ-024 Reset mid-transaction SHALL discard the pending request; a store not yet at the DONE-entry edge SHALL NOT be written.
REQ-025 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-026 Macro DMEM_ALIGN_CHECK_EN defined: latched addr[1:0]!=0 SHALL suppress the write, load mem_data_o=0, and assert mem_err_o=1 in the DONE cycle only (ready still pulses).
REQ-027 Macro undefined: addr[1:0] ignored, access proceeds normally, mem_err_o tied 0.

Verification
REQ-028 Reset then store addr 0x00000010 data 0xDEADBEEF, WAIT_CYC=2 -> ready high exactly 3 cycles after accept edge, one cycle wide.
REQ-029 Load addr 0x00000010 after REQ-028 -> mem_data_o=0xDEADBEEF in ready cycle, held afterwards.
REQ-030 ADDR_W=10, store 0x00001010 data 0x12345678, load 0x00000010 -> 0x12345678 (wrap).
REQ-031 Assert resetn=0 during WAIT of store 0x20 data 0xAAAA5555; after reset load 0x20 -> previous value, ready/data=0 during reset.
REQ-032 DMEM_ALIGN_CHECK_EN defined, store 0x00000012 -> mem_err_o=1 with ready, subsequent load 0x10 unchanged; undefined -> err 0, store lands at 0x10.
REQ-033 WAIT_CYC=0, ce held high continuously with alternating store/load -> ready every 2nd cycle, data correct.
